// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: access size encoding and the data-memory arbiter state type.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/riscv_dmem_arb_sel.sv
// Grant selection for the data-memory arbiter: fixed priority p0 > p1 with a starvation
// counter, or round-robin when RISCV_DMEM_ARB_RR_EN is defined.
module riscv_dmem_arb_sel #(
    parameter int HOLD_MAX = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant_en,
    output logic gnt_p0,
    output logic gnt_p1
);

    logic pick_p1;

`ifdef RISCV_DMEM_ARB_RR_EN
    logic last_p0;

    always_comb begin
        pick_p1 = p1_req & (~p0_req | last_p0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_p0 <= 1'b0;
        end else if (gnt_p0 | gnt_p1) begin
            last_p0 <= gnt_p0;
        end
    end
`else
    localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    logic [CW-1:0] hold_cnt;
    logic          hold_hit;

    // p1 wins a simultaneous request once p0 has had HOLD_MAX grants in a row over it
    always_comb begin
        hold_hit = (hold_cnt >= CW'(HOLD_MAX));
        pick_p1  = p1_req & (~p0_req | hold_hit);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
        end else if (!p1_req || gnt_p1) begin
            hold_cnt <= '0;
        end else if (gnt_p0 && !hold_hit) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

    assign gnt_p1 = grant_en & pick_p1;
    assign gnt_p0 = grant_en & p0_req & ~pick_p1;

endmodule

// File: rtl/riscv_dmem_arb.sv
// Two-port data-memory arbiter (LSU port 0, debug port 1) with one outstanding access.
// Round-robin arbitration is selected by defining RISCV_DMEM_ARB_RR_EN.
//
//  state | meaning
//  IDLE  | no access outstanding; a grant may be made
//  BUSY  | access outstanding; response goes to the granted port
//  DRAIN | access outstanding after flush; response is discarded
module riscv_dmem_arb
    import biu_constants_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int HOLD_MAX = 15
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,

    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [XLEN-1:0] p0_adr,
    input  logic [XLEN-1:0] p0_d,
    input  biu_size_t       p0_size,
    output logic            p0_ack,
    output logic [XLEN-1:0] p0_q,
    output logic            p0_misaligned,
    output logic            p0_page_fault,

    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [XLEN-1:0] p1_adr,
    input  logic [XLEN-1:0] p1_d,
    input  biu_size_t       p1_size,
    output logic            p1_ack,
    output logic [XLEN-1:0] p1_q,
    output logic            p1_misaligned,
    output logic            p1_page_fault,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_adr,
    output logic [XLEN-1:0] dmem_d,
    output biu_size_t       dmem_size,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_q,
    input  logic            dmem_misaligned,
    input  logic            dmem_page_fault,

    output logic            busy
);

    arb_state_t      state_q, state_d;
    logic            grant_en, gnt_p0, gnt_p1;
    logic            sel_p1_q;
    logic            we_q;
    logic [XLEN-1:0] adr_q, d_q;
    biu_size_t       size_q;
    logic            resp_p0, resp_p1, deliver;

    assign grant_en = (state_q == IDLE) & ~flush;

    riscv_dmem_arb_sel #(.HOLD_MAX(HOLD_MAX)) u_sel (
        .clk      (clk),
        .rstn     (rstn),
        .p0_req   (p0_req),
        .p1_req   (p1_req),
        .grant_en (grant_en),
        .gnt_p0   (gnt_p0),
        .gnt_p1   (gnt_p1)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_p0 | gnt_p1) state_d = BUSY;
            BUSY:    if (dmem_ack)        state_d = IDLE;
                     else if (flush)      state_d = DRAIN;
            DRAIN:   if (dmem_ack)        state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_p1_q <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            d_q      <= '0;
            size_q   <= BYTE;
        end else if (gnt_p0 | gnt_p1) begin
            sel_p1_q <= gnt_p1;
            we_q     <= gnt_p1 ? p1_we   : p0_we;
            adr_q    <= gnt_p1 ? p1_adr  : p0_adr;
            d_q      <= gnt_p1 ? p1_d    : p0_d;
            size_q   <= gnt_p1 ? p1_size : p0_size;
        end
    end

    // A flush coinciding with the ack still retires the access but withholds the strobe
    always_comb begin
        resp_p0       = (state_q == BUSY) & ~sel_p1_q;
        resp_p1       = (state_q == BUSY) &  sel_p1_q;
        deliver       = dmem_ack & ~flush;
        dmem_req      = (state_q != IDLE);
        busy          = (state_q != IDLE);
        dmem_we       = we_q;
        dmem_adr      = adr_q;
        dmem_d        = d_q;
        dmem_size     = size_q;
        p0_ack        = resp_p0 & deliver;
        p1_ack        = resp_p1 & deliver;
        p0_q          = resp_p0 ? dmem_q : '0;
        p1_q          = resp_p1 ? dmem_q : '0;
        p0_misaligned = resp_p0 & dmem_misaligned;
        p1_misaligned = resp_p1 & dmem_misaligned;
        p0_page_fault = resp_p0 & dmem_page_fault;
        p1_page_fault = resp_p1 & dmem_page_fault;
    end

endmodule

// File: doc/riscv_dmem_arb.md
RISCV_DMEM_ARB -- requirements
Module: riscv_dmem_arb

Interface
REQ-001 Parameter XLEN, default 32, sets the data and address width.
REQ-002 Parameter HOLD_MAX, default 15, sets the maximum consecutive grants to the priority port before a pending lower-priority request is forced.
REQ-003 clk  input  1  clock.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  pipeline flush (st_flush | du_flush); suppresses delivery of the in-flight response.
REQ-006 p0_req, p0_we  input  1 each  port 0 (EX-stage LSU) request and write-enable.
REQ-007 p0_adr, p0_d  input  XLEN each  port 0 address and write data.
REQ-008 p0_size  input  biu_size_t  port 0 access size.
REQ-009 p0_ack  output  1  port 0 response strobe.
REQ-010 p0_q  output  XLEN  port 0 read data.
REQ-011 p0_misaligned, p0_page_fault  output  1 each  port 0 error flags.
REQ-012 p1_req, p1_we, p1_adr, p1_d, p1_size, p1_ack, p1_q, p1_misaligned, p1_page_fault: the same set for port 1 (debug-unit memory access), with the same directions and widths.
REQ-013 dmem_req, dmem_we  output  1 each  downstream request and write-enable.
REQ-014 dmem_adr, dmem_d  output  XLEN each  downstream address and write data.
REQ-015 dmem_size  output  biu_size_t  downstream access size.
REQ-016 dmem_ack  input  1  downstream response strobe.
REQ-017 dmem_q  input  XLEN  downstream read data.
REQ-018 dmem_misaligned, dmem_page_fault  input  1 each  downstream error flags.
REQ-019 busy  output  1  transaction outstanding; the EX stage ORs it into its stall.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY and DRAIN, with at most one transaction outstanding.
REQ-021 IDLE with any pxN_req high SHALL grant one port, register its we/adr/d/size and enter BUSY; dmem_req rises on the next cycle, giving 1-cycle request latency.
REQ-022 In BUSY, dmem_req SHALL stay high and the dmem_* outputs SHALL stay stable, driven from registers, until dmem_ack.
REQ-023 On dmem_ack in BUSY, pN_ack of the granted port SHALL pulse for that same cycle.
REQ-024 pN_q, pN_misaligned and pN_page_fault SHALL pass dmem_q and the error flags combinationally, and SHALL be 0 for the non-granted port.
REQ-025 On dmem_ack the FSM SHALL return to IDLE; back-to-back grants therefore have a 1-cycle gap.
REQ-026 flush in BUSY SHALL move the FSM to DRAIN and keep dmem_req high.
REQ-027 In DRAIN, dmem_ack SHALL produce no pN_ack and SHALL return the FSM to IDLE.
REQ-028 flush in IDLE SHALL block any grant in that cycle.
REQ-029 Default arbitration SHALL be fixed priority, p0 over p1.
REQ-030 A saturating counter SHALL count consecutive p0 grants made while p1_req is high; at HOLD_MAX the next grant goes to p1.
REQ-031 The counter SHALL clear on every p1 grant and on every cycle p1_req is low.
REQ-032 busy SHALL be high in BUSY and DRAIN.
REQ-033 A requester SHALL hold pN_req and its attributes until its pN_ack; dropping pN_req while granted SHALL NOT cancel the downstream access.
REQ-034 The only fault source SHALL be dmem_ack while the FSM is IDLE, which SHALL be ignored.

Reset
REQ-035 On rstn low the FSM SHALL be IDLE, the counter and last-grant register 0, and all outputs 0; dmem_adr and dmem_d SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon it with no pN_ack.

Configuration
REQ-037 With RISCV_DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the port not granted last wins, and the HOLD_MAX counter is removed.
REQ-038 Without RISCV_DMEM_ARB_RR_EN, REQ-029 to REQ-031 SHALL apply.

Structure
REQ-039 The state enum type arb_state_t SHALL be added to biu_constants_pkg beside biu_size_t.
REQ-040 Grant selection SHALL be a separate sub-module, riscv_dmem_arb_sel, containing the priority/RR logic and the counter; the FSM and datapath registers stay in the top module.

Verification
REQ-041 Bench SHALL cover: p0 read of 0x100 while IDLE -> dmem_req at +1 with adr 0x100; dmem_ack with q=0xDEADBEEF -> p0_ack with p0_q=0xDEADBEEF in the same cycle, p1_ack=0.
REQ-042 Bench SHALL cover: p0 and p1 requesting every cycle, HOLD_MAX=3, RR off -> grant sequence p0,p0,p0,p1,p0,p0,p0,p1.
REQ-043 Bench SHALL cover: RR on, both requesting continuously -> grant sequence p0,p1,p0,p1.
REQ-044 Bench SHALL cover: flush 2 cycles after a p1 grant, dmem_ack at 5 cycles -> dmem_req held until ack, p1_ack never asserted, busy falls after the ack.
REQ-045 Bench SHALL cover: dmem_ack with dmem_page_fault=1 on a p0 write -> p0_ack=1 and p0_page_fault=1, p1 flags 0.
REQ-046 Bench SHALL cover: rstn low mid-BUSY -> all outputs 0 immediately; after release, a new p1 request is granted normally.
